ps2_key_encoder: RTL and testbench
==================================

PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

Interface
REQ-001 SHALL have parameter FILT, default 8, meaning clk_sys cycles a synchronised PS/2 clock level must hold before it is accepted.
REQ-002 SHALL have parameter TIMEOUT, default 50000, meaning the maximum clk_sys cycles allowed between falling edges inside one frame.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk_in, input, 1 bit: raw PS/2 clock line, asynchronous to clk_sys.
REQ-006 SHALL have port ps2_data_in, input, 1 bit: raw PS/2 data line, asynchronous to clk_sys.
REQ-007 SHALL have port ps2_key, output, 11 bits: [10] toggles once per event, [9] pressed, [8] extended (E0), [7:0] scan code.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a rejected frame.

Function
REQ-009 SHALL pass both inputs through 2-flop synchronisers.
REQ-010 SHALL hold a filtered clock level that changes only after the synchronised clock differs from it for FILT consecutive cycles.
REQ-011 SHALL sample synchronised data on each falling edge of the filtered clock, and only there.
REQ-012 SHALL use receive FSM states R_IDLE, R_DATA, R_PAR, R_STOP, with an edge in R_IDLE sampling data=0 entering R_DATA.
REQ-013 SHALL ignore an edge in R_IDLE that samples data=1; no error.
REQ-014 SHALL shift 8 data bits LSB first in R_DATA (3-bit counter), then take the odd-parity bit in R_PAR and the stop bit in R_STOP.
REQ-015 SHALL accept a byte only if the 8 data bits plus parity hold an odd number of ones and stop=1; otherwise pulse frame_err, drop the byte and return to R_IDLE.
REQ-016 SHALL run a timeout counter outside R_IDLE, cleared on each edge; on reaching TIMEOUT: frame_err pulse, R_IDLE, partial byte dropped.
REQ-017 SHALL use decode FSM states D_IDLE, D_E0, D_F0, D_E0F0, D_SKIP, advanced once per accepted byte.
REQ-018 SHALL step from D_IDLE on E0 to D_E0, on F0 to D_F0, and on E1 to D_SKIP with skip count 7.
REQ-019 SHALL step from D_E0 on F0 to D_E0F0; E0 repeated in D_E0 stays in D_E0.
REQ-020 SHALL emit an event for any other byte b: ps2_key[9]=1 in D_IDLE/D_E0 or 0 in D_F0/D_E0F0; [8]=1 in D_E0/D_E0F0; [7:0]=b; [10] inverted; decode then to D_IDLE.
REQ-021 SHALL update all 11 ps2_key bits in the same cycle, exactly 1 clk_sys after the stop-bit edge; they stay stable until the next event.
REQ-022 SHALL in D_IDLE discard bytes 00, AA, EE, FA, FC, FE, FF (device responses) with no event.
REQ-023 SHALL in D_SKIP decrement the count per byte and return to D_IDLE after the 7th byte; no events from a Pause sequence.
REQ-024 SHALL force decode to D_IDLE on any frame_err so that a prefix is never applied across a bad frame.
REQ-025 SHALL let an edge and a timeout in the same cycle resolve as the edge (counter cleared, no error).
REQ-026 SHALL emit at most one event per 11-bit frame, with [10] wrapping naturally (toggle only).

Reset
REQ-027 SHALL, while reset_n=0: ps2_key=11'h000, frame_err=0, R_IDLE, D_IDLE, counters 0, filtered clock=1, synchronisers=1.
REQ-028 SHALL on reset mid-frame drop the partial byte and emit no event; the next frame decodes normally after release.

Verification
REQ-029 SHALL cover: frame 0x1C (A), parity 0, stop 1 -> ps2_key=11'h61C, one cycle after stop edge.
REQ-030 SHALL cover: bytes F0,1C after REQ-029 -> ps2_key=11'h01C ([10]=0, [9]=0); no event on F0.
REQ-031 SHALL cover: bytes E0,75 then E0,F0,75 -> 11'h775, then 11'h175.
REQ-032 SHALL cover: 0x29 frame with parity flipped -> frame_err one cycle, ps2_key unchanged; following 0x29 good frame -> 11'h629 (toggle relative to previous).
REQ-033 SHALL cover: start plus 4 data bits, then clock idle TIMEOUT cycles -> frame_err pulse; next full 0x14 frame -> event 0x014 pressed; also a 4-cycle glitch on ps2_clk_in -> no sample taken.
REQ-034 SHALL cover: Pause sequence E1 14 77 E1 F0 14 F0 77 then 0x5A -> no event for the 8 bytes, then 11'h?5A pressed ([10] toggled once); FA in D_IDLE -> no event.

Source files
------------

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder -- PS/2 keyboard receiver and scan-code set 2 decoder.
//
// The raw PS/2 lines are synchronised and the clock line is debounced.
// Each falling edge of the filtered clock samples one bit of an 11-bit frame:
// start, 8 data bits (LSB first), odd parity and stop. Accepted bytes feed a
// prefix decoder (E0 / F0 / E1-Pause) that emits one key event per make or
// break code.
//
// Parameters
//   FILT     clk_sys cycles a new synchronised PS/2 clock level must hold
//   TIMEOUT  max clk_sys cycles between falling edges inside one frame
// Ports
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_key      [10] event toggle, [9] pressed, [8] extended, [7:0] scan code
//   frame_err    one-cycle pulse when a frame is rejected
module ps2_key_encoder #(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_DATA = 2'd1;
  localparam logic [1:0] R_PAR  = 2'd2;
  localparam logic [1:0] R_STOP = 2'd3;

  localparam logic [2:0] D_IDLE = 3'd0;
  localparam logic [2:0] D_E0   = 3'd1;
  localparam logic [2:0] D_F0   = 3'd2;
  localparam logic [2:0] D_E0F0 = 3'd3;
  localparam logic [2:0] D_SKIP = 3'd4;

  // ---------------------------------------------------------------- sync
  logic [1:0] clk_sync, dat_sync;
  logic       clk_s, dat_s;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_data_in};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // -------------------------------------------------------------- filter
  // The filtered level flips on the FILT-th consecutive disagreeing cycle;
  // any agreeing cycle restarts the run, so short glitches never get through.
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip, fall;

  assign filt_flip = (clk_s != clk_filt) && (filt_cnt == FILT_LAST);
  assign fall      = filt_flip && clk_filt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------------- receive
  logic [1:0]    rx_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          byte_ok, stop_bad, timeout, rx_err;

  // Frame is good when data+parity carry an odd number of ones and stop=1.
  assign byte_ok  = fall && (rx_state == R_STOP) && dat_s && (^{shreg, par_bit});
  assign stop_bad = fall && (rx_state == R_STOP) && !byte_ok;
  // An edge in the expiry cycle wins: it clears the counter instead.
  assign timeout  = (rx_state != R_IDLE) && !fall && (to_cnt == TO_LAST);
  assign rx_err   = stop_bad || timeout;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= R_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      if (rx_state == R_IDLE || fall || timeout) to_cnt <= '0;
      else                                       to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        rx_state <= R_IDLE;
      end else if (fall) begin
        case (rx_state)
          R_IDLE: if (!dat_s) begin
            rx_state <= R_DATA;
            bit_cnt  <= '0;
          end
          R_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= R_PAR;
          end
          R_PAR: begin
            par_bit  <= dat_s;
            rx_state <= R_STOP;
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------- decode
  logic [2:0] dec_state;
  logic [2:0] skip_cnt;
  logic       is_resp;

  // Device responses that are not keystrokes.
  always_comb begin
    is_resp = 1'b0;
    case (shreg)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_resp = 1'b1;
      default: is_resp = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dec_state <= D_IDLE;
      skip_cnt  <= '0;
      ps2_key   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= rx_err;
      if (rx_err) begin
        // A bad frame cancels any pending prefix.
        dec_state <= D_IDLE;
        skip_cnt  <= '0;
      end else if (byte_ok) begin
        case (dec_state)
          D_IDLE: begin
            if (shreg == 8'hE0)      dec_state <= D_E0;
            else if (shreg == 8'hF0) dec_state <= D_F0;
            else if (shreg == 8'hE1) begin
              dec_state <= D_SKIP;
              skip_cnt  <= 3'd7;
            end else if (!is_resp)
              ps2_key <= {~ps2_key[10], 1'b1, 1'b0, shreg};
          end
          D_E0: begin
            if (shreg == 8'hF0)      dec_state <= D_E0F0;
            else if (shreg != 8'hE0) begin
              ps2_key   <= {~ps2_key[10], 1'b1, 1'b1, shreg};
              dec_state <= D_IDLE;
            end
          end
          D_F0: begin
            ps2_key   <= {~ps2_key[10], 1'b0, 1'b0, shreg};
            dec_state <= D_IDLE;
          end
          D_E0F0: begin
            ps2_key   <= {~ps2_key[10], 1'b0, 1'b1, shreg};
            dec_state <= D_IDLE;
          end
          D_SKIP: begin
            // Remaining bytes of the Pause sequence produce no events.
            skip_cnt <= skip_cnt - 1'b1;
            if (skip_cnt == 3'd1) dec_state <= D_IDLE;
          end
          default: dec_state <= D_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: frames are bit-banged on the raw lines
// and ps2_key / frame_err are compared against hand-computed constants.
module tb_ps2_key_encoder;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int n_assert = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int ev_cnt   = 0;
  logic [10:0] key_q = '0;

  ps2_key_encoder #(.FILT(8), .TIMEOUT(1000)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_key     (ps2_key),
    .frame_err   (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Count frame_err high cycles and ps2_key changes, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (frame_err === 1'b1) err_cnt++;
    if (ps2_key !== key_q) ev_cnt++;
    key_q = ps2_key;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic d);
    @(negedge clk_sys); ps2_data_in = d;
    repeat (10) @(negedge clk_sys); ps2_clk_in = 1'b0;
    repeat (20) @(negedge clk_sys); ps2_clk_in = 1'b1;
    repeat (10) @(negedge clk_sys);
  endtask

  // Full frame. With chk_lat set, ps2_key is checked 9 and 10 clk_sys edges
  // after the raw stop-bit fall (2 sync + FILT filter cycles).
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                            input bit chk_lat, input logic [10:0] k_before,
                            input logic [10:0] k_after);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ par_flip);
    if (!chk_lat) ps2_bit(stop);
    else begin
      @(negedge clk_sys); ps2_data_in = stop;
      repeat (10) @(negedge clk_sys); ps2_clk_in = 1'b0;
      repeat (9) @(posedge clk_sys); #1;
      check("latency_before", 32'(ps2_key), 32'(k_before));
      @(posedge clk_sys); #1;
      check("latency_after", 32'(ps2_key), 32'(k_after));
      repeat (10) @(negedge clk_sys); ps2_clk_in = 1'b1;
      repeat (10) @(negedge clk_sys);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 1'b0, 11'h000, 11'h000);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_ferr", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    // Make A, exact latency
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11'h000, 11'h61C);
    send(8'hF0);
    check("f0_no_event", 32'(ps2_key), 32'h61C);
    send(8'h1C);
    check("break_a", 32'(ps2_key), 32'h01C);
    send(8'hE0); send(8'h75);
    check("ext_make", 32'(ps2_key), 32'h775);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_break", 32'(ps2_key), 32'h175);

    // Bad parity then good frame
    send_frame(8'h29, 1'b1, 1'b1, 1'b0, 11'h000, 11'h000);
    check("par_err_cnt", 32'(err_cnt), 32'd1);
    check("par_err_key", 32'(ps2_key), 32'h175);
    send_frame(8'h29, 1'b0, 1'b1, 1'b1, 11'h175, 11'h629);

    // Timeout after start + 4 data bits
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (1100) @(negedge clk_sys);
    check("timeout_err_cnt", 32'(err_cnt), 32'd2);
    check("timeout_key", 32'(ps2_key), 32'h629);
    send(8'h14);
    check("after_timeout", 32'(ps2_key), 32'h214);

    // 4-cycle glitch with data low must not start a frame
    @(negedge clk_sys); ps2_data_in = 1'b0; ps2_clk_in = 1'b0;
    repeat (4) @(negedge clk_sys);
    ps2_clk_in = 1'b1; ps2_data_in = 1'b1;
    repeat (1100) @(negedge clk_sys);
    check("glitch_err_cnt", 32'(err_cnt), 32'd2);
    send(8'h33);
    check("after_glitch", 32'(ps2_key), 32'h633);
    check("event_count", 32'(ev_cnt), 32'd7);

    // Pause sequence: no events
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_no_event", 32'(ev_cnt), 32'd7);
    check("pause_key", 32'(ps2_key), 32'h633);
    send(8'h5A);
    check("after_pause", 32'(ps2_key), 32'h25A);
    send(8'hFA);
    check("fa_discard", 32'(ps2_key), 32'h25A);
    send(8'h1C);
    check("after_fa", 32'(ps2_key), 32'h61C);
    check("event_count2", 32'(ev_cnt), 32'd9);

    // Reset mid-frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge clk_sys); reset_n = 1'b0; ps2_data_in = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("midreset_key", 32'(ps2_key), 32'h000);
    check("midreset_ferr", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    send(8'h1C);
    check("after_reset", 32'(ps2_key), 32'h61C);
    check("midreset_no_err", 32'(err_cnt), 32'd2);

    // E0 prefix dropped by bad stop bit
    send(8'hE0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 11'h000, 11'h000);
    check("stop_err_cnt", 32'(err_cnt), 32'd3);
    send(8'h75);
    check("prefix_cleared", 32'(ps2_key), 32'h275);

    // E0 prefix dropped by bad parity; F0 75 is a plain break
    send(8'hE0);
    send_frame(8'h42, 1'b1, 1'b1, 1'b0, 11'h000, 11'h000);
    check("par_err_cnt2", 32'(err_cnt), 32'd4);
    send(8'hF0); send(8'h75);
    check("prefix_cleared2", 32'(ps2_key), 32'h475);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
